// File: rtl/e203_ifu_irbuf.sv
// ---------------------------------------------------------------------------
// e203_ifu_irbuf
//   Two-entry instruction register buffer between the IFU fetch stage and
//   decode/dispatch. It stores {instr, pc, prdt_taken, misalgn, buserr} per
//   entry. Every output toward decode and toward fetch comes from registered
//   state only, so there is no combinational ready/valid path through it.
//
//   Optional feature (macro E203_IRBUF_MULDIV_B2B_EN):
//     When defined, a history register remembers the last popped instruction
//     and flags a head instruction that completes a fusible mul/div pair
//     (MULH*/MUL, DIV/REM, DIVU/REMU on the same operands). When undefined,
//     ir_muldiv_b2b is tied to 0 and the FIFO behaves identically.
//
// Ports
//   clk              : clock, all state on rising edge
//   rst_n            : synchronous active-low reset
//   ifu_o_valid      : fetch presents an instruction
//   ifu_o_ready      : buffer can accept (not full)
//   ifu_o_ir/_pc     : fetched instruction and its pc
//   ifu_o_prdt_taken, ifu_o_misalgn, ifu_o_buserr : fetch side flags
//   flush_req        : pipeline flush, empties the buffer
//   ir_valid         : head entry valid toward decode
//   ir_ready         : decode consumes the head
//   ir_instr/_pc/_prdt_taken/_misalgn/_buserr : head payload
//   ir_muldiv_b2b    : head is the second half of a fusible mul/div pair
// ---------------------------------------------------------------------------
module e203_ifu_irbuf #(
  parameter int E203_INSTR_SIZE = 32,
  parameter int E203_PC_SIZE    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ifu_o_valid,
  output logic                       ifu_o_ready,
  input  logic [E203_INSTR_SIZE-1:0] ifu_o_ir,
  input  logic [E203_PC_SIZE-1:0]    ifu_o_pc,
  input  logic                       ifu_o_prdt_taken,
  input  logic                       ifu_o_misalgn,
  input  logic                       ifu_o_buserr,
  input  logic                       flush_req,
  output logic                       ir_valid,
  input  logic                       ir_ready,
  output logic [E203_INSTR_SIZE-1:0] ir_instr,
  output logic [E203_PC_SIZE-1:0]    ir_pc,
  output logic                       ir_prdt_taken,
  output logic                       ir_misalgn,
  output logic                       ir_buserr,
  output logic                       ir_muldiv_b2b
);

  typedef struct packed {
    logic [E203_INSTR_SIZE-1:0] instr;
    logic [E203_PC_SIZE-1:0]    pc;
    logic                       prdt_taken;
    logic                       misalgn;
    logic                       buserr;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     wdata;
  entry_t     head;
  logic       rptr_q;
  logic       wptr_q;
  logic [1:0] count_q;
  logic       full;
  logic       push;
  logic       pop;

  assign full        = (count_q == 2'd2);
  assign ifu_o_ready = ~full;
  assign ir_valid    = (count_q != 2'd0);
  assign push        = ifu_o_valid & ifu_o_ready;
  assign pop         = ir_valid & ir_ready;

  assign wdata = '{instr:      ifu_o_ir,
                   pc:         ifu_o_pc,
                   prdt_taken: ifu_o_prdt_taken,
                   misalgn:    ifu_o_misalgn,
                   buserr:     ifu_o_buserr};

  assign head          = mem_q[rptr_q];
  assign ir_instr      = head.instr;
  assign ir_pc         = head.pc;
  assign ir_prdt_taken = head.prdt_taken;
  assign ir_misalgn    = head.misalgn;
  assign ir_buserr     = head.buserr;

  // FIFO storage, pointers and occupancy. Flush empties the buffer and
  // discards any push/pop of the same cycle; reset dominates everything.
  // Push only happens when not full and pop only when not empty, so the
  // count stays inside 0..2 by construction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rptr_q   <= 1'b0;
      wptr_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush_req) begin
      count_q <= 2'd0;
      rptr_q  <= 1'b0;
      wptr_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef E203_IRBUF_MULDIV_B2B_EN
  logic [31:0] hd;
  logic [2:0]  hd_f3;
  logic [4:0]  hd_rd;
  logic [4:0]  hd_rs1;
  logic [4:0]  hd_rs2;
  logic        hd_is_md;
  logic        hd_first_ok;
  logic        pair_ok;
  logic        hv_q;
  logic [2:0]  h_kind_q;
  logic [4:0]  h_rs1_q;
  logic [4:0]  h_rs2_q;
  logic [4:0]  h_rd_q;

  // The popped instruction is always the head, so one decoder serves both
  // the history update and the pair match.
  assign hd       = head.instr[31:0];
  assign hd_f3    = hd[14:12];
  assign hd_rd    = hd[11:7];
  assign hd_rs1   = hd[19:15];
  assign hd_rs2   = hd[24:20];
  assign hd_is_md = (hd[6:0] == 7'b0110011) && (hd[31:25] == 7'b0000001);

  // A first half must be MULH/MULHSU/MULHU/DIV/DIVU and must not overwrite
  // its own sources, otherwise the second half would read a changed value.
  assign hd_first_ok = hd_is_md && (hd_f3 >= 3'b001) && (hd_f3 <= 3'b101) &&
                       (hd_rd != hd_rs1) && (hd_rd != hd_rs2) &&
                       (hd_rd != 5'd0);

  // History of the last popped instruction; untouched in cycles without pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hv_q     <= 1'b0;
      h_kind_q <= 3'b000;
      h_rs1_q  <= 5'd0;
      h_rs2_q  <= 5'd0;
      h_rd_q   <= 5'd0;
    end else if (flush_req) begin
      hv_q <= 1'b0;
    end else if (pop) begin
      hv_q     <= hd_first_ok;
      h_kind_q <= hd_f3;
      h_rs1_q  <= hd_rs1;
      h_rs2_q  <= hd_rs2;
      h_rd_q   <= hd_rd;
    end
  end

  // Legal pairs: high multiply -> MUL, DIV -> REM, DIVU -> REMU.
  always_comb begin
    pair_ok = 1'b0;
    case (h_kind_q)
      3'b001, 3'b010, 3'b011: pair_ok = (hd_f3 == 3'b000);
      3'b100:                 pair_ok = (hd_f3 == 3'b110);
      3'b101:                 pair_ok = (hd_f3 == 3'b111);
      default:                pair_ok = 1'b0;
    endcase
  end

  assign ir_muldiv_b2b = ir_valid & hv_q & hd_is_md & pair_ok &
                         (hd_rs1 == h_rs1_q) & (hd_rs2 == h_rs2_q) &
                         (hd_rd == h_rd_q);
`else
  assign ir_muldiv_b2b = 1'b0;
`endif

endmodule

// File: tb/tb_e203_ifu_irbuf.sv
// ---------------------------------------------------------------------------
// tb_e203_ifu_irbuf
//   Directed, table-driven bench for e203_ifu_irbuf. Each table row gives the
//   inputs driven during one cycle and the outputs expected in that same
//   cycle (which depend only on state from earlier edges). A short streaming
//   sequence follows the table. Expectations for ir_muldiv_b2b follow the
//   E203_IRBUF_MULDIV_B2B_EN macro.
// ---------------------------------------------------------------------------
module tb_e203_ifu_irbuf;

`ifdef E203_IRBUF_MULDIV_B2B_EN
  localparam logic B2B = 1'b1;
`else
  localparam logic B2B = 1'b0;
`endif

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MULH = 32'h0220_92B3;
  localparam logic [31:0] MUL5 = 32'h0220_82B3;
  localparam logic [31:0] MUL6 = 32'h0220_8333;
  localparam logic [31:0] DIV5 = 32'h0220_C2B3;
  localparam logic [31:0] REM5 = 32'h0220_E2B3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_o_valid;
  logic        ifu_o_ready;
  logic [31:0] ifu_o_ir;
  logic [31:0] ifu_o_pc;
  logic        ifu_o_prdt_taken;
  logic        ifu_o_misalgn;
  logic        ifu_o_buserr;
  logic        flush_req;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_instr;
  logic [31:0] ir_pc;
  logic        ir_prdt_taken;
  logic        ir_misalgn;
  logic        ir_buserr;
  logic        ir_muldiv_b2b;

  always #5 clk = ~clk;

  e203_ifu_irbuf #(.E203_INSTR_SIZE(32), .E203_PC_SIZE(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ifu_o_valid      (ifu_o_valid),
    .ifu_o_ready      (ifu_o_ready),
    .ifu_o_ir         (ifu_o_ir),
    .ifu_o_pc         (ifu_o_pc),
    .ifu_o_prdt_taken (ifu_o_prdt_taken),
    .ifu_o_misalgn    (ifu_o_misalgn),
    .ifu_o_buserr     (ifu_o_buserr),
    .flush_req        (flush_req),
    .ir_valid         (ir_valid),
    .ir_ready         (ir_ready),
    .ir_instr         (ir_instr),
    .ir_pc            (ir_pc),
    .ir_prdt_taken    (ir_prdt_taken),
    .ir_misalgn       (ir_misalgn),
    .ir_buserr        (ir_buserr),
    .ir_muldiv_b2b    (ir_muldiv_b2b)
  );

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  flg;
    logic        flush;
    logic        rdy;
    logic        e_valid;
    logic        e_ordy;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [2:0]  e_flg;
    logic        e_b2b;
    logic        chk_pl;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // One comparison: counts it and reports a mismatch.
  task automatic cmp(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add_vec(input logic rst_v, input logic valid,
                         input logic [31:0] instr, input logic [31:0] pc,
                         input logic [2:0] flg, input logic flush,
                         input logic rdy, input logic e_valid,
                         input logic e_ordy, input logic [31:0] e_instr,
                         input logic [31:0] e_pc, input logic [2:0] e_flg,
                         input logic e_b2b, input logic chk_pl);
    vec_t v;
    v.rst_n = rst_v;     v.valid = valid;     v.instr = instr;
    v.pc = pc;           v.flg = flg;         v.flush = flush;
    v.rdy = rdy;         v.e_valid = e_valid; v.e_ordy = e_ordy;
    v.e_instr = e_instr; v.e_pc = e_pc;       v.e_flg = e_flg;
    v.e_b2b = e_b2b;     v.chk_pl = chk_pl;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n            = v.rst_n;
    ifu_o_valid      = v.valid;
    ifu_o_ir         = v.instr;
    ifu_o_pc         = v.pc;
    {ifu_o_prdt_taken, ifu_o_misalgn, ifu_o_buserr} = v.flg;
    flush_req        = v.flush;
    ir_ready         = v.rdy;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    cmp("ir_valid", idx, {31'd0, ir_valid}, {31'd0, v.e_valid});
    cmp("ifu_o_ready", idx, {31'd0, ifu_o_ready}, {31'd0, v.e_ordy});
    cmp("ir_muldiv_b2b", idx, {31'd0, ir_muldiv_b2b}, {31'd0, v.e_b2b});
    if (v.e_valid || v.chk_pl) begin
      cmp("ir_instr", idx, ir_instr, v.e_instr);
      cmp("ir_pc", idx, ir_pc, v.e_pc);
      cmp("ir_flags", idx, {29'd0, ir_prdt_taken, ir_misalgn, ir_buserr},
          {29'd0, v.e_flg});
    end
  endtask

  initial begin
    // rst, vld, instr, pc, flg, flush, rdy | e_vld, e_ordy, e_instr, e_pc, e_flg, e_b2b, chk
    // Basic push then pop after reset release
    add_vec(1,1,NOP,32'h8000_0000,0,0,1, 0,1,0,0,0,0,1);
    add_vec(1,0,0,0,0,0,1, 1,1,NOP,32'h8000_0000,0,0,0);
    add_vec(1,0,0,0,0,0,1, 0,1,0,0,0,0,0);
    // Fill with ir_ready low, third push refused, drain in order
    add_vec(1,1,32'h0010_0093,32'h100,3'b001,0,0, 0,1,0,0,0,0,0);
    add_vec(1,1,32'h0020_0113,32'h104,3'b010,0,0, 1,1,32'h0010_0093,32'h100,3'b001,0,0);
    add_vec(1,1,32'h0030_0193,32'h108,3'b000,0,0, 1,0,32'h0010_0093,32'h100,3'b001,0,0);
    add_vec(1,1,32'h0030_0193,32'h108,3'b000,0,1, 1,0,32'h0010_0093,32'h100,3'b001,0,0);
    add_vec(1,0,0,0,0,0,0, 1,1,32'h0020_0113,32'h104,3'b010,0,0);
    add_vec(1,0,0,0,0,0,1, 1,1,32'h0020_0113,32'h104,3'b010,0,0);
    add_vec(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
    // Simultaneous push/pop, full with pop, head held while stalled
    add_vec(1,1,32'h0040_0213,32'h200,0,0,1, 0,1,0,0,0,0,0);
    add_vec(1,1,32'h0050_0293,32'h204,0,0,1, 1,1,32'h0040_0213,32'h200,0,0,0);
    add_vec(1,1,32'h0060_0313,32'h208,0,0,0, 1,1,32'h0050_0293,32'h204,0,0,0);
    add_vec(1,1,32'h0070_0393,32'h20c,0,0,1, 1,0,32'h0050_0293,32'h204,0,0,0);
    add_vec(1,0,0,0,0,0,0, 1,1,32'h0060_0313,32'h208,0,0,0);
    add_vec(1,0,0,0,0,0,0, 1,1,32'h0060_0313,32'h208,0,0,0);
    add_vec(1,0,0,0,0,0,1, 1,1,32'h0060_0313,32'h208,0,0,0);
    add_vec(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
    // Flush while full with a push offered; flush with accepted push
    add_vec(1,1,32'h0080_0413,32'h300,0,0,0, 0,1,0,0,0,0,0);
    add_vec(1,1,32'h0090_0493,32'h304,0,0,0, 1,1,32'h0080_0413,32'h300,0,0,0);
    add_vec(1,1,32'h00a0_0513,32'h308,0,1,1, 1,0,32'h0080_0413,32'h300,0,0,0);
    add_vec(1,0,0,0,0,0,1, 0,1,0,0,0,0,0);
    add_vec(1,1,32'h00b0_0593,32'h30c,0,1,0, 0,1,0,0,0,0,0);
    add_vec(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
    add_vec(1,1,32'h00c0_0613,32'h310,0,0,1, 0,1,0,0,0,0,0);
    add_vec(1,0,0,0,0,0,1, 1,1,32'h00c0_0613,32'h310,0,0,0);
    add_vec(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
    // MULH -> MUL x5 fuses; MULH -> MUL x6 does not
    add_vec(1,1,MULH,32'h400,0,0,0, 0,1,0,0,0,0,0);
    add_vec(1,1,MUL5,32'h404,0,0,1, 1,1,MULH,32'h400,0,0,0);
    add_vec(1,1,MULH,32'h408,0,0,1, 1,1,MUL5,32'h404,0,B2B,0);
    add_vec(1,1,MUL6,32'h40c,0,0,1, 1,1,MULH,32'h408,0,0,0);
    add_vec(1,0,0,0,0,0,0, 1,1,MUL6,32'h40c,0,0,0);
    add_vec(1,0,0,0,0,0,1, 1,1,MUL6,32'h40c,0,0,0);
    // History survives idle cycles; output gated by ir_valid
    add_vec(1,1,MULH,32'h410,0,0,0, 0,1,0,0,0,0,0);
    add_vec(1,0,0,0,0,0,1, 1,1,MULH,32'h410,0,0,0);
    add_vec(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
    add_vec(1,1,MUL5,32'h414,0,0,0, 0,1,0,0,0,0,0);
    add_vec(1,0,0,0,0,0,0, 1,1,MUL5,32'h414,0,B2B,0);
    add_vec(1,0,0,0,0,0,1, 1,1,MUL5,32'h414,0,B2B,0);
    add_vec(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
    // DIV -> REM fuses; DIV, flush, REM does not
    add_vec(1,1,DIV5,32'h500,0,0,0, 0,1,0,0,0,0,0);
    add_vec(1,1,REM5,32'h504,0,0,1, 1,1,DIV5,32'h500,0,0,0);
    add_vec(1,0,0,0,0,0,0, 1,1,REM5,32'h504,0,B2B,0);
    add_vec(1,1,DIV5,32'h508,0,0,1, 1,1,REM5,32'h504,0,B2B,0);
    add_vec(1,0,0,0,0,0,1, 1,1,DIV5,32'h508,0,0,0);
    add_vec(1,0,0,0,0,1,0, 0,1,0,0,0,0,0);
    add_vec(1,1,REM5,32'h50c,0,0,0, 0,1,0,0,0,0,0);
    add_vec(1,0,0,0,0,0,0, 1,1,REM5,32'h50c,0,0,0);
    add_vec(1,0,0,0,0,0,1, 1,1,REM5,32'h50c,0,0,0);
    add_vec(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);
    // Reset while full dominates push, pop and flush
    add_vec(1,1,32'h00d0_0693,32'h600,3'b111,0,0, 0,1,0,0,0,0,0);
    add_vec(1,1,32'h00e0_0713,32'h604,3'b000,0,0, 1,1,32'h00d0_0693,32'h600,3'b111,0,0);
    add_vec(0,1,32'h00f0_0793,32'h608,3'b000,1,1, 1,0,32'h00d0_0693,32'h600,3'b111,0,0);
    add_vec(1,0,0,0,0,0,1, 0,1,0,0,0,0,1);
    add_vec(1,0,0,0,0,0,0, 0,1,0,0,0,0,0);

    // Initial reset for two edges with idle inputs
    rst_n = 1'b0; ifu_o_valid = 1'b0; ifu_o_ir = '0; ifu_o_pc = '0;
    ifu_o_prdt_taken = 1'b0; ifu_o_misalgn = 1'b0; ifu_o_buserr = 1'b0;
    flush_req = 1'b0; ir_ready = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // Streaming: one push and one pop every cycle, head lags by one cycle
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      rst_n = 1'b1; flush_req = 1'b0; ir_ready = 1'b1;
      ifu_o_valid = (k < 6);
      ifu_o_ir    = 32'h0000_0013 | (k << 20);
      ifu_o_pc    = 32'h700 + 32'(4 * k);
      {ifu_o_prdt_taken, ifu_o_misalgn, ifu_o_buserr} = 3'b000;
      #1;
      cmp("stream_ready", 100 + k, {31'd0, ifu_o_ready}, 32'd1);
      cmp("stream_valid", 100 + k, {31'd0, ir_valid}, (k > 0) ? 32'd1 : 32'd0);
      if (k > 0) begin
        cmp("stream_pc", 100 + k, ir_pc, 32'h700 + 32'(4 * (k - 1)));
        cmp("stream_instr", 100 + k, ir_instr, 32'h0000_0013 | ((k - 1) << 20));
      end
    end
    @(negedge clk);
    ifu_o_valid = 1'b0; ir_ready = 1'b0;
    #1;
    cmp("stream_empty", 107, {31'd0, ir_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e203_ifu_irbuf.md
E203_IFU_IRBUF -- requirements
Module: e203_ifu_irbuf

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port ifu_o_valid, input, 1: fetch presents an instruction.
REQ-004 SHALL have port ifu_o_ready, output, 1: buffer can accept.
REQ-005 SHALL have ports ifu_o_ir (input, E203_INSTR_SIZE), ifu_o_pc (input, E203_PC_SIZE), and ifu_o_prdt_taken, ifu_o_misalgn, ifu_o_buserr (input, 1 each): fetch payload.
REQ-006 SHALL have port flush_req, input, 1: pipeline flush from commit.
REQ-007 SHALL have port ir_valid, output, 1: head entry valid toward decode.
REQ-008 SHALL have port ir_ready, input, 1: decode/dispatch consumes the head.
REQ-009 SHALL have ports ir_instr, ir_pc, ir_prdt_taken, ir_misalgn, ir_buserr (output, widths as REQ-005): head payload, driving decode i_instr, i_pc, i_prdt_taken, i_misalgn, i_buserr.
REQ-010 SHALL have port ir_muldiv_b2b, output, 1: head is a fusible mul/div pair partner; drives decode i_muldiv_b2b.

Function
REQ-011 SHALL implement a 2-entry FIFO of {instr, pc, prdt_taken, misalgn, buserr}; push = ifu_o_valid & ifu_o_ready; pop = ir_valid & ir_ready.
REQ-012 SHALL drive ifu_o_ready = ~full from registered state only; no combinational path from ir_ready.
REQ-013 SHALL drive all ir_* outputs from registers/head mux only; an entry pushed at cycle N is visible at ir_valid in cycle N+1 at the earliest.
REQ-014 SHALL sustain one push and one pop per cycle: count 1 with push and pop stays 1; empty with push becomes 1; full with pop becomes 1.
REQ-015 SHALL use 1-bit read/write pointers wrapping 1->0 and a 2-bit count (0..2); count never exceeds 2 or goes below 0.
REQ-016 SHALL hold head payload stable while ir_valid=1 and ir_ready=0.
REQ-017 SHALL, on flush_req=1, set count=0 and both pointers to 0 at the next edge; a push or pop in the same cycle is discarded; ir_valid=0 the following cycle.
REQ-018 SHALL keep ifu_o_ready=1 in the cycle after flush.
REQ-019 SHALL keep a b2b history register {hv, h_kind, h_rs1, h_rs2, h_rd}, updated on every pop with the popped instruction; hv=1 only if it is RV32 OP with func7=0000001 and func3 in {001,010,011,100,101}, h_rd!=h_rs1, h_rd!=h_rs2, h_rd!=x0.
REQ-020 SHALL assert ir_muldiv_b2b when ir_valid & hv and head is RV32 OP func7=0000001 with rs1=h_rs1, rs2=h_rs2, rd=h_rd, and pair (prev func3 -> head func3) is 001/010/011->000, 100->110, or 101->111.
REQ-021 SHALL clear hv on flush_req and on any pop not meeting REQ-019; hv unchanged in cycles without pop.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, set count=0, pointers=0, hv=0; ir_valid=0, ir_muldiv_b2b=0, ifu_o_ready=1 the next cycle.
REQ-023 SHALL reset payload storage to 0; ir_instr, ir_pc and error flags read 0 after reset.
REQ-024 SHALL let reset dominate flush_req, push and pop in the same cycle, including mid-operation with the FIFO full.

Configuration
REQ-025 SHALL, with E203_IRBUF_MULDIV_B2B_EN defined, implement REQ-019..REQ-021.
REQ-026 SHALL, without E203_IRBUF_MULDIV_B2B_EN, omit the history register and tie ir_muldiv_b2b to 0; FIFO behaviour identical.

Verification
REQ-027 SHALL cover: reset release, push pc=0x80000000 instr=0x00000013 at cycle 1, ir_ready=1 -> ir_valid=1 cycle 2 with that payload, ifu_o_ready=1 throughout.
REQ-028 SHALL cover: ir_ready=0, three pushes -> ifu_o_ready=0 after second, third not accepted; ir_ready=1 -> order 1,2 out, ifu_o_ready=1 one cycle after first pop.
REQ-029 SHALL cover: FIFO full, flush_req=1 with ifu_o_valid=1 -> next cycle ir_valid=0, count 0, flushed-cycle instruction never appears.
REQ-030 SHALL cover: pop MULH x5,x1,x2 (0x022092B3) then head MUL x5,x1,x2 (0x022082B3) -> ir_muldiv_b2b=1; with head MUL x6,x1,x2 -> 0.
REQ-031 SHALL cover: pop DIV x5,x1,x2, flush_req, then REM x5,x1,x2 -> ir_muldiv_b2b=0; macro undefined -> always 0.
REQ-032 SHALL cover: rst_n=0 while full with ir_ready=1 -> next cycle ir_valid=0, ifu_o_ready=1, ir_instr=0.
